regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised successor to the ARM 16x32 register file. It provides a configurable number of registered read ports, one write port with same-cycle write-through bypass, and a dedicated auto-incrementing PC register. It supports single-register clear and a bulk-clear sweep sequencer that zeroes every register over NREGS cycles. The block sits between the decode stage (read addresses) and the ALU/writeback path (write data).

Parameters:
DATA_W, 32, register width in bits
NREGS, 16, number of registers
ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NREGS
NRD, 2, number of read ports
PC_IDX, 15, index of the auto-incrementing PC register
PC_STEP, 4, PC increment per PC_INC cycle

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous reset, active-high
WE  in  1  write enable
WA  in  ADDR_W  write address
WD  in  DATA_W  write data
CLR_EN  in  1  single-register clear enable
CLR_ADDR  in  ADDR_W  register to clear
RE  in  1  read enable, shared by all ports
RA  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
RD_DATA  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
RD_VALID  out  1  RD_DATA updated by the previous edge
PC_INC  in  1  advance PC register by PC_STEP
PC_OUT  out  DATA_W  current PC register contents (combinational from the register)
SWEEP_REQ  in  1  start bulk clear
BUSY  out  1  sweep in progress
SWEEP_DONE  out  1  one-cycle pulse when the sweep completes

Behaviour:
- One clock domain; reset is synchronous and active-high (RST sampled on the CLK rising edge).
- Reset: all registers 0; RD_DATA 0, RD_VALID 0, BUSY 0, SWEEP_DONE 0, PC_OUT 0; FSM to IDLE; sweep index 0. Reset mid-sweep aborts the sweep with no SWEEP_DONE pulse.
- Next-state per register, highest priority first:
  1. sweep clear, when BUSY and index==i;
  2. CLR_EN && !BUSY && CLR_ADDR==i gives 0;
  3. WE && !BUSY && WA==i gives WD;
  4. i==PC_IDX && PC_INC && !BUSY gives reg+PC_STEP, wrapping mod 2**DATA_W;
  5. otherwise hold.
- Out-of-range addresses (>= NREGS): writes and clears are ignored; reads return 0.
- Read: when RE=1 at an edge, RD_DATA[k] <= next-state value of register RA[k]. Latency is one cycle. Bypass is inherent: same-cycle write returns WD, same-cycle clear returns 0, same-cycle PC increment returns the incremented value.
- RE=0: RD_DATA holds its previous value. RD_VALID <= RE every cycle.
- Reads remain legal during a sweep and return the next-state value (0 for the register being swept).
- Multiple ports may read the same address; each receives identical data.
- WE, CLR_EN and PC_INC presented while BUSY=1 are dropped silently and not queued.
- Sweep FSM:
  - IDLE: SWEEP_REQ=1 moves to SWEEP with index=0.
  - SWEEP: BUSY=1; clears reg[index] each edge and increments index; when index==NREGS-1, moves to DONE.
  - DONE: BUSY=0, SWEEP_DONE=1 for exactly one cycle; returns to IDLE. WE/CLR/PC_INC are accepted in DONE.
  - SWEEP_REQ is ignored in SWEEP and DONE. A SWEEP_REQ held high re-arms only from IDLE, one cycle after DONE.
  - Timing: SWEEP_REQ sampled at edge n gives BUSY=1 for edges n+1..n+NREGS, SWEEP_DONE during the cycle after edge n+NREGS.
- PC_OUT always reflects reg[PC_IDX].

Test Plan:
- RST for 2 cycles, then RE=1 with RA={0,15} → after 1 cycle RD_DATA={0,0}, RD_VALID=1, PC_OUT=0.
- WE=1, WA=3, WD=0xDEADBEEF with RE=1, RA[0]=3 in the same cycle → RD_DATA[0]=0xDEADBEEF on the next cycle (bypass); reading port 1 at RA=3 two cycles later also returns 0xDEADBEEF.
- PC: write reg15=0xFFFFFFFC, then PC_INC=1 for 2 cycles → PC_OUT goes 0x00000000, then 0x00000004. WE to 15 with WD=0x100 while PC_INC=1 → PC_OUT=0x100.
- Same cycle WE=1, WA=5, WD=0x55 and CLR_EN=1, CLR_ADDR=5 → reg5=0. Then CLR_EN on 5 after writing 0x77 → read returns 0.
- Fill all 16 registers with i+1, then pulse SWEEP_REQ → BUSY=1 for exactly 16 cycles, then SWEEP_DONE one-cycle pulse, all reads 0. WE to reg2 during BUSY is dropped (reads 0 after). SWEEP_REQ during BUSY is ignored.
- Start a sweep, assert RST at sweep cycle 5 → next cycle BUSY=0, SWEEP_DONE never pulses, all registers 0. Writes work on the following cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-through reads,
// an auto-incrementing PC register, single-register clear and a
// bulk-clear sweep sequencer that zeroes one register per cycle.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 4,
  parameter int NRD     = 2,
  parameter int PC_IDX  = 15,
  parameter int PC_STEP = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WA,
  input  logic [DATA_W-1:0]     WD,
  input  logic                  CLR_EN,
  input  logic [ADDR_W-1:0]     CLR_ADDR,
  input  logic                  RE,
  input  logic [NRD*ADDR_W-1:0] RA,
  output logic [NRD*DATA_W-1:0] RD_DATA,
  output logic                  RD_VALID,
  input  logic                  PC_INC,
  output logic [DATA_W-1:0]     PC_OUT,
  input  logic                  SWEEP_REQ,
  output logic                  BUSY,
  output logic                  SWEEP_DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweepState_e;

  sweepState_e state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [NRD*DATA_W-1:0] rdData_q, rdData_d;
  logic                  rdValid_q;
  logic [DATA_W-1:0]     rdSel;

  logic busy;

  assign busy       = (state_q == SWEEP);
  assign BUSY       = busy;
  assign SWEEP_DONE = (state_q == DONE);
  assign PC_OUT     = regs_q[PC_IDX];
  assign RD_DATA    = rdData_q;
  assign RD_VALID   = rdValid_q;

  // Sweep sequencer state and index registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep sequencer next-state: IDLE -> SWEEP over every index -> one-cycle DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (SWEEP_REQ) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == ADDR_W'(NREGS - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Per-register next value: sweep clear beats clear beats write beats PC increment
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (busy && idx_q == ADDR_W'(i)) begin
        regs_d[i] = '0;
      end else if (!busy && CLR_EN && CLR_ADDR == ADDR_W'(i)) begin
        regs_d[i] = '0;
      end else if (!busy && WE && WA == ADDR_W'(i)) begin
        regs_d[i] = WD;
      end else if (!busy && PC_INC && i == PC_IDX) begin
        regs_d[i] = regs_q[i] + DATA_W'(PC_STEP);
      end
    end
  end

  // Register array update; reset zeroes every entry
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREGS; i++) begin
      if (RST) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports select from next-state values so same-cycle updates bypass through
  always_comb begin
    rdData_d = rdData_q;
    rdSel    = '0;
    if (RE) begin
      for (int k = 0; k < NRD; k++) begin
        rdSel = '0;
        for (int i = 0; i < NREGS; i++) begin
          if (RA[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
            rdSel = regs_d[i];
          end
        end
        rdData_d[k*DATA_W +: DATA_W] = rdSel;
      end
    end
  end

  // Read data and valid registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdData_q  <= rdData_d;
      rdValid_q <= RE;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random
// traffic, all compared against a behavioural model of the register file.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int NP = 2;
  localparam int PCI = 15;
  localparam int PCS = 4;

  logic            clock;
  logic            reset;
  logic            writeEn;
  logic [AW-1:0]   writeAddr;
  logic [DW-1:0]   writeData;
  logic            clrEn;
  logic [AW-1:0]   clrAddr;
  logic            readEn;
  logic [NP*AW-1:0] readAddr;
  logic [NP*DW-1:0] readData;
  logic            readValid;
  logic            pcInc;
  logic [DW-1:0]   pcOut;
  logic            sweepReq;
  logic            busyOut;
  logic            doneOut;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] memModel [NR];
  logic [DW-1:0] rdModel  [NP];
  bit            validModel;
  bit            sweeping;
  int            sweepPos;
  bit            donePulse;

  regfile_mp #(
    .DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .NRD(NP), .PC_IDX(PCI), .PC_STEP(PCS)
  ) dut (
    .CLK(clock),
    .RST(reset),
    .WE(writeEn),
    .WA(writeAddr),
    .WD(writeData),
    .CLR_EN(clrEn),
    .CLR_ADDR(clrAddr),
    .RE(readEn),
    .RA(readAddr),
    .RD_DATA(readData),
    .RD_VALID(readValid),
    .PC_INC(pcInc),
    .PC_OUT(pcOut),
    .SWEEP_REQ(sweepReq),
    .BUSY(busyOut),
    .SWEEP_DONE(doneOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic idleInputs();
    reset     = 1'b0;
    writeEn   = 1'b0;
    writeAddr = '0;
    writeData = '0;
    clrEn     = 1'b0;
    clrAddr   = '0;
    readEn    = 1'b0;
    readAddr  = '0;
    pcInc     = 1'b0;
    sweepReq  = 1'b0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs
  task automatic modelEdge();
    logic [DW-1:0] nextMem [NR];
    int a;
    if (reset) begin
      for (int i = 0; i < NR; i++) memModel[i] = '0;
      for (int k = 0; k < NP; k++) rdModel[k] = '0;
      validModel = 0;
      sweeping   = 0;
      sweepPos   = 0;
      donePulse  = 0;
      return;
    end
    for (int i = 0; i < NR; i++) nextMem[i] = memModel[i];
    if (sweeping) begin
      nextMem[sweepPos] = '0;
    end else begin
      // apply lowest priority first so higher-priority actions overwrite
      if (pcInc) nextMem[PCI] = memModel[PCI] + DW'(PCS);
      if (writeEn && int'(writeAddr) < NR) nextMem[writeAddr] = writeData;
      if (clrEn && int'(clrAddr) < NR) nextMem[clrAddr] = '0;
    end
    if (readEn) begin
      for (int k = 0; k < NP; k++) begin
        a = int'(readAddr[k*AW +: AW]);
        rdModel[k] = (a < NR) ? nextMem[a] : '0;
      end
    end
    validModel = readEn;
    if (sweeping) begin
      if (sweepPos == NR - 1) begin
        sweeping  = 0;
        sweepPos  = 0;
        donePulse = 1;
      end else begin
        sweepPos++;
      end
    end else if (donePulse) begin
      donePulse = 0;
    end else if (sweepReq) begin
      sweeping = 1;
      sweepPos = 0;
    end
    for (int i = 0; i < NR; i++) memModel[i] = nextMem[i];
  endtask

  // One clock of stimulus followed by a full comparison against the model
  task automatic applyStimulus();
    @(posedge clock);
    modelEdge();
    #1;
    checkOutput("rd0",   64'(readData[0 +: DW]),  64'(rdModel[0]));
    checkOutput("rd1",   64'(readData[DW +: DW]), 64'(rdModel[1]));
    checkOutput("valid", 64'(readValid), 64'(validModel));
    checkOutput("busy",  64'(busyOut),   64'(sweeping));
    checkOutput("done",  64'(doneOut),   64'(donePulse));
    checkOutput("pc",    64'(pcOut),     64'(memModel[PCI]));
  endtask

  task automatic readPair(input int a0, input int a1);
    idleInputs();
    readEn   = 1'b1;
    readAddr = {AW'(a1), AW'(a0)};
    applyStimulus();
  endtask

  initial begin
    int busyCycles;
    int doneCount;
    for (int i = 0; i < NR; i++) memModel[i] = 'x;
    rdModel[0] = 'x; rdModel[1] = 'x;
    sweeping = 0; sweepPos = 0; donePulse = 0; validModel = 0;

    // Reset, then read registers 0 and 15
    idleInputs();
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    readPair(0, 15);
    checkOutput("rst_rd",    64'(readData),  64'h0);
    checkOutput("rst_valid", 64'(readValid), 64'h1);
    checkOutput("rst_pc",    64'(pcOut),     64'h0);

    // Write-through bypass on port 0, then plain read on port 1
    idleInputs();
    writeEn = 1'b1; writeAddr = 4'd3; writeData = 32'hDEADBEEF;
    readEn = 1'b1; readAddr = {4'd0, 4'd3};
    applyStimulus();
    checkOutput("bypass_rd0", 64'(readData[0 +: DW]), 64'hDEADBEEF);
    idleInputs();
    applyStimulus();
    readPair(0, 3);
    checkOutput("later_rd1", 64'(readData[DW +: DW]), 64'hDEADBEEF);

    // PC wrap and write-over-increment priority
    idleInputs();
    writeEn = 1'b1; writeAddr = 4'd15; writeData = 32'hFFFFFFFC;
    applyStimulus();
    idleInputs(); pcInc = 1'b1;
    applyStimulus();
    checkOutput("pc_wrap", 64'(pcOut), 64'h0);
    applyStimulus();
    checkOutput("pc_step", 64'(pcOut), 64'h4);
    writeEn = 1'b1; writeAddr = 4'd15; writeData = 32'h100;
    applyStimulus();
    checkOutput("pc_wr_prio", 64'(pcOut), 64'h100);

    // Clear beats write; clear after write
    idleInputs();
    writeEn = 1'b1; writeAddr = 4'd5; writeData = 32'h55;
    clrEn = 1'b1; clrAddr = 4'd5;
    readEn = 1'b1; readAddr = {4'd5, 4'd5};
    applyStimulus();
    checkOutput("clr_prio", 64'(readData), 64'h0);
    idleInputs();
    writeEn = 1'b1; writeAddr = 4'd5; writeData = 32'h77;
    applyStimulus();
    idleInputs();
    clrEn = 1'b1; clrAddr = 4'd5; readEn = 1'b1; readAddr = {4'd0, 4'd5};
    applyStimulus();
    checkOutput("clr_rd", 64'(readData[0 +: DW]), 64'h0);

    // Fill, sweep, and check dropped write / ignored request while busy
    for (int i = 0; i < NR; i++) begin
      idleInputs();
      writeEn = 1'b1; writeAddr = AW'(i); writeData = DW'(i + 1);
      applyStimulus();
    end
    readPair(2, 9);
    checkOutput("fill_rd", 64'(readData), {32'd10, 32'd3});
    idleInputs(); sweepReq = 1'b1;
    applyStimulus();
    busyCycles = 0; doneCount = 0;
    for (int c = 0; c < 22; c++) begin
      if (busyOut) busyCycles++;
      if (doneOut) doneCount++;
      idleInputs();
      if (c == 0) begin writeEn = 1'b1; writeAddr = 4'd2; writeData = 32'hAB; end
      if (c == 3) sweepReq = 1'b1;
      applyStimulus();
    end
    checkOutput("sweep_busy_cycles", 64'(busyCycles), 64'd16);
    checkOutput("sweep_done_pulses", 64'(doneCount),  64'd1);
    for (int i = 0; i < NR; i += 2) begin
      readPair(i, i + 1);
      checkOutput("sweep_zero", 64'(readData), 64'h0);
    end

    // Reset mid-sweep aborts without a done pulse
    for (int i = 0; i < NR; i++) begin
      idleInputs();
      writeEn = 1'b1; writeAddr = AW'(i); writeData = 32'hA000 + DW'(i);
      applyStimulus();
    end
    idleInputs(); sweepReq = 1'b1;
    applyStimulus();
    idleInputs();
    for (int c = 0; c < 5; c++) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    checkOutput("abort_busy", 64'(busyOut), 64'h0);
    idleInputs();
    doneCount = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (doneOut) doneCount++;
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    for (int i = 0; i < NR; i += 2) begin
      readPair(i, i + 1);
      checkOutput("abort_zero", 64'(readData), 64'h0);
    end
    idleInputs();
    writeEn = 1'b1; writeAddr = 4'd7; writeData = 32'h1234;
    applyStimulus();
    readPair(7, 7);
    checkOutput("post_abort_wr", 64'(readData), {32'h1234, 32'h1234});

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      writeEn   = ($urandom_range(0, 1) == 1);
      writeAddr = AW'($urandom_range(0, NR - 1));
      writeData = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : DW'($urandom);
      clrEn     = ($urandom_range(0, 5) == 0);
      clrAddr   = ($urandom_range(0, 1) == 0) ? writeAddr : AW'($urandom_range(0, NR - 1));
      readEn    = ($urandom_range(0, 3) != 0);
      readAddr  = NP*AW'($urandom);
      pcInc     = ($urandom_range(0, 2) == 0);
      sweepReq  = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
